// File: rtl/sfa_pkg.sv
// Shared SFA tile definitions: datapath word type and switch CONF encodings
// used by the output FIFO, sfa_outSwitch and the configuration controller.
package sfa_pkg;

  localparam int unsigned SFA_DW = 32;

  typedef logic [SFA_DW-1:0] sfa_word_t;

  localparam logic [1:0] CONF_N = 2'b00;
  localparam logic [1:0] CONF_E = 2'b01;
  localparam logic [1:0] CONF_S = 2'b10;
  localparam logic [1:0] CONF_W = 2'b11;

endpackage

// File: rtl/sfa_fifoMem.sv
// DEPTH x 32 storage for sfa_outfifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sfa_fifoMem
  import sfa_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sfa_word_t     wdata,
  input  logic [AW-1:0] raddr,
  output sfa_word_t     rdata
);

  sfa_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfa_outfifo.sv
// Elastic first-word-fall-through AXI4-Stream buffer feeding sfa_outSwitch,
// with DRAIN input gating and EMPTY/COUNT status for the config controller.
module sfa_outfifo
  import sfa_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          ACLK,
  input  logic          ARESET,
  output logic          si_tready,
  input  logic          si_tvalid,
  input  sfa_word_t     si_tdata,
  input  logic          mo_tready,
  output logic          mo_tvalid,
  output sfa_word_t     mo_tdata,
  input  logic          DRAIN,
  output logic          EMPTY,
  output logic [AW:0]   COUNT
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;
  sfa_word_t     head_data;

  // Ready depends only on registered occupancy, never on mo_tready.
  assign si_tready = !ARESET && (cnt_q != CNT_FULL) && !DRAIN;
  assign mo_tvalid = (cnt_q != '0);
  assign mo_tdata  = mo_tvalid ? head_data : '0;
  assign EMPTY     = (cnt_q == '0);
  assign COUNT     = cnt_q;

  assign wr_en = si_tvalid && si_tready;
  assign rd_en = mo_tvalid && mo_tready;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      wp_d = wp_q + AW'(1);
    end
    if (rd_en) begin
      rp_d = rp_q + AW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  sfa_fifoMem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (ACLK),
    .we    (wr_en),
    .waddr (wp_q),
    .wdata (si_tdata),
    .raddr (rp_q),
    .rdata (head_data)
  );

endmodule

// File: tb/tb_sfa_outfifo.sv
// Directed bench for sfa_outfifo: reset, fill/full, streaming wrap,
// backpressure with a queue model, drain and reset mid-stream.
module tb_sfa_outfifo;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        si_tready;
  logic        si_tvalid;
  logic [31:0] si_tdata;
  logic        mo_tready;
  logic        mo_tvalid;
  logic [31:0] mo_tdata;
  logic        DRAIN;
  logic        EMPTY;
  logic [4:0]  COUNT;

  int total = 0;
  int bad   = 0;

  sfa_outfifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .si_tready (si_tready),
    .si_tvalid (si_tvalid),
    .si_tdata  (si_tdata),
    .mo_tready (mo_tready),
    .mo_tvalid (mo_tvalid),
    .mo_tdata  (mo_tdata),
    .DRAIN     (DRAIN),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int          sent, rcvd, cyc;
    logic        wr, rd, stall_prev;
    logic [31:0] stall_d;

    // Reset with a beat presented
    ARESET = 1'b1; si_tvalid = 1'b1; si_tdata = 32'hDEAD0001;
    mo_tready = 1'b0; DRAIN = 1'b0;
    #1;
    chk("rst_rdy_low", si_tready, 1'b0);
    repeat (3) step();
    chk("rst_rdy_hold", si_tready, 1'b0);
    ARESET = 1'b0; si_tvalid = 1'b0;
    #1;
    chk("rst_empty", EMPTY, 1'b1);
    chk("rst_count", COUNT, 5'd0);
    chk("rst_mvalid", mo_tvalid, 1'b0);
    chk("rst_mdata", mo_tdata, 32'h0);
    chk("rst_rdy_rel", si_tready, 1'b1);
    step();
    chk("rst_nothing", COUNT, 5'd0);

    // Fill to full, hold 17th beat, one read frees a slot
    for (int i = 0; i < 16; i++) begin
      si_tvalid = 1'b1; si_tdata = 32'h100 + 32'(i);
      step();
      if (i == 0) chk("fill_first_vis", mo_tdata, 32'h100);
    end
    si_tdata = 32'h110;
    #1;
    chk("full_count", COUNT, 5'd16);
    chk("full_rdy", si_tready, 1'b0);
    step();
    chk("full_held", COUNT, 5'd16);
    mo_tready = 1'b1;
    #1;
    chk("full_head", mo_tdata, 32'h100);
    step();
    mo_tready = 1'b0;
    #1;
    chk("full_rdy_back", si_tready, 1'b1);
    chk("full_cnt15", COUNT, 5'd15);
    chk("full_next", mo_tdata, 32'h101);
    step();
    si_tvalid = 1'b0;
    chk("full_accept", COUNT, 5'd16);
    mo_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("full_drain", mo_tdata, 32'h101 + 32'(i));
      step();
    end
    chk("full_empty", EMPTY, 1'b1);

    // Streaming with wrap: count holds at 1
    for (int k = 0; k < 40; k++) begin
      si_tvalid = 1'b1; si_tdata = 32'(k);
      #1;
      chk("strm_valid", mo_tvalid, (k > 0));
      if (k > 0) begin
        chk("strm_data", mo_tdata, 32'(k - 1));
        chk("strm_count", COUNT, 5'd1);
      end
      step();
    end
    si_tvalid = 1'b0;
    #1;
    chk("strm_last", mo_tdata, 32'd39);
    step();
    chk("strm_empty", EMPTY, 1'b1);

    // Random backpressure against a queue model
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; stall_d = '0;
    mo_tready = 1'b0;
    while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
      if (!si_tvalid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        si_tvalid = 1'b1; si_tdata = 32'h0001_0000 + 32'(sent);
      end
      mo_tready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_count", COUNT, 32'(q.size()));
      chk("bp_rdy", si_tready, (q.size() != 16));
      chk("bp_mvalid", mo_tvalid, (q.size() != 0));
      if (q.size() != 0) chk("bp_data", mo_tdata, q[0]);
      if (stall_prev) chk("bp_stable", mo_tdata, stall_d);
      wr = si_tvalid && (q.size() != 16);
      rd = (q.size() != 0) && mo_tready;
      stall_prev = (q.size() != 0) && !mo_tready;
      if (q.size() != 0) stall_d = q[0];
      step();
      if (rd) begin void'(q.pop_front()); rcvd++; end
      if (wr) begin q.push_back(si_tdata); sent++; si_tvalid = 1'b0; end
      cyc++;
    end
    si_tvalid = 1'b0; mo_tready = 1'b0;
    chk("bp_rcvd", 32'(rcvd), 32'd1000);
    chk("bp_end_empty", EMPTY, 1'b1);

    // Drain: input gated at once, output keeps emptying
    for (int i = 0; i < 5; i++) begin
      si_tvalid = 1'b1; si_tdata = 32'h500 + 32'(i);
      step();
    end
    DRAIN = 1'b1; si_tdata = 32'h5FF;
    #1;
    chk("drn_rdy", si_tready, 1'b0);
    mo_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("drn_data", mo_tdata, 32'h500 + 32'(i));
      step();
    end
    chk("drn_empty", EMPTY, 1'b1);
    chk("drn_rdy_still", si_tready, 1'b0);
    step();
    chk("drn_blocked", COUNT, 5'd0);
    DRAIN = 1'b0;
    #1;
    chk("drn_rdy_rel", si_tready, 1'b1);
    step();
    si_tvalid = 1'b0;
    chk("drn_held_cnt", COUNT, 5'd1);
    chk("drn_held_data", mo_tdata, 32'h5FF);
    step();
    chk("drn_final_empty", EMPTY, 1'b1);
    mo_tready = 1'b0;

    // Reset mid-stream
    for (int i = 0; i < 7; i++) begin
      si_tvalid = 1'b1; si_tdata = 32'h700 + 32'(i);
      step();
    end
    chk("mrst_count7", COUNT, 5'd7);
    ARESET = 1'b1; si_tdata = 32'h7FF;
    step();
    ARESET = 1'b0; si_tvalid = 1'b0;
    #1;
    chk("mrst_count", COUNT, 5'd0);
    chk("mrst_mvalid", mo_tvalid, 1'b0);
    chk("mrst_mdata", mo_tdata, 32'h0);
    si_tvalid = 1'b1; si_tdata = 32'hABCD;
    step();
    si_tvalid = 1'b0;
    chk("mrst_first", mo_tdata, 32'hABCD);
    chk("mrst_cnt1", COUNT, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
